// File: rtl/layer_mem_arbiter.sv
// Two-requester arbiter in front of the layer memories, with bursts of up to BURST_MAX beats.
// Define ARB_ROUND_ROBIN_EN to use round-robin contests from IDLE; without it, requester 0 has fixed priority.
module layer_mem_arbiter #(
   parameter int unsigned BURST_MAX = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [2:0]  sel0,
   input  logic [2:0]  sel1,
   input  logic [11:0] addr0,
   input  logic [11:0] addr1,
   input  logic [19:0] wdata0,
   input  logic [19:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [19:0] rdata,
   output logic        cwr,
   output logic        crd,
   output logic [2:0]  csel,
   output logic [11:0] caddr_wr,
   output logic [11:0] caddr_rd,
   output logic [19:0] cdata_wr,
   input  logic [19:0] cdata_rd
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] GRANT0 = 2'd1;
   localparam logic [1:0] GRANT1 = 2'd2;
   localparam logic [7:0] BMAX   = 8'(BURST_MAX);

   logic [1:0]  state, state_nx;
   logic [7:0]  cnt, cnt_nx, cnt_inc;
   logic        acc0, acc1, acc;
   logic        pick1, rd_src;
   logic        we_m;
   logic [2:0]  sel_m;
   logic [11:0] addr_m;
   logic [19:0] wdata_m;

   assign gnt0    = (state == GRANT0);
   assign gnt1    = (state == GRANT1);
   assign acc0    = req0 & gnt0;
   assign acc1    = req1 & gnt1;
   assign acc     = acc0 | acc1;
   assign cnt_inc = cnt + 8'd1;
   assign we_m    = acc1 ? we1    : we0;
   assign sel_m   = acc1 ? sel1   : sel0;
   assign addr_m  = acc1 ? addr1  : addr0;
   assign wdata_m = acc1 ? wdata1 : wdata0;

`ifdef ARB_ROUND_ROBIN_EN
   logic last;

   // Resets to 1 so the first contest goes to requester 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         last <= 1'b1;
      else if (state_nx == GRANT0)
         last <= 1'b0;
      else if (state_nx == GRANT1)
         last <= 1'b1;
   end

   assign pick1 = ~last;
`else
   assign pick1 = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            cnt_nx = 8'd0;
            if (req0 && req1)
               state_nx = pick1 ? GRANT1 : GRANT0;
            else if (req0)
               state_nx = GRANT0;
            else if (req1)
               state_nx = GRANT1;
         end
         GRANT0: begin
            if (!req0 || cnt_inc == BMAX) begin
               cnt_nx = 8'd0;
               if (req1)
                  state_nx = GRANT1;
               else if (req0)
                  state_nx = GRANT0;
               else
                  state_nx = IDLE;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         GRANT1: begin
            if (!req1 || cnt_inc == BMAX) begin
               cnt_nx = 8'd0;
               if (req0)
                  state_nx = GRANT0;
               else if (req1)
                  state_nx = GRANT1;
               else
                  state_nx = IDLE;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // rd_src remembers who owns the read now in the crd stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cwr      <= 1'b0;
         crd      <= 1'b0;
         csel     <= 3'd0;
         caddr_wr <= 12'd0;
         caddr_rd <= 12'd0;
         cdata_wr <= 20'd0;
         rd_src   <= 1'b0;
         rdata    <= 20'd0;
         rvalid0  <= 1'b0;
         rvalid1  <= 1'b0;
      end else begin
         cwr     <= acc & we_m;
         crd     <= acc & ~we_m;
         csel    <= acc ? sel_m : 3'd0;
         rvalid0 <= crd & ~rd_src;
         rvalid1 <= crd & rd_src;
         if (crd)
            rdata <= cdata_rd;
         if (acc && we_m) begin
            caddr_wr <= addr_m;
            cdata_wr <= wdata_m;
         end
         if (acc && !we_m) begin
            caddr_rd <= addr_m;
            rd_src   <= acc1;
         end
      end
   end

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Bench for layer_mem_arbiter: directed vectors, hand sequences and random traffic against an owner/queue model.
module tb_layer_mem_arbiter;

   localparam int BM = 4;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0, req1, we0, we1;
   logic [2:0]  sel0, sel1;
   logic [11:0] addr0, addr1;
   logic [19:0] wdata0, wdata1, cdata_rd;
   logic        gnt0, gnt1, rvalid0, rvalid1, cwr, crd;
   logic [19:0] rdata, cdata_wr;
   logic [2:0]  csel;
   logic [11:0] caddr_wr, caddr_rd;

   layer_mem_arbiter #(.BURST_MAX(BM)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .sel0(sel0), .sel1(sel1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .cwr(cwr), .crd(crd), .csel(csel),
      .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
      .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: owner of the grant (-1 none), beats in this burst, pending read owner
   int          owner, cnt, last, pend;
   logic        m_cwr, m_crd, m_rv0, m_rv1;
   logic [2:0]  m_csel;
   logic [11:0] m_cawr, m_card;
   logic [19:0] m_cdwr, m_rdata;

   function automatic logic [72:0] pk(
      input logic g0, input logic g1, input logic cw, input logic cr,
      input logic [2:0] cs, input logic [11:0] aw, input logic [11:0] ar,
      input logic [19:0] dw, input logic v0, input logic v1,
      input logic [19:0] rd);
      return {g0, g1, cw, cr, cs, aw, ar, dw, v0, v1, rd};
   endfunction

   function automatic logic [72:0] dut_act();
      return pk(gnt0, gnt1, cwr, crd, csel, caddr_wr, caddr_rd,
                cdata_wr, rvalid0, rvalid1, rdata);
   endfunction

   function automatic logic [72:0] model_exp();
      return pk(owner == 0, owner == 1, m_cwr, m_crd, m_csel, m_cawr,
                m_card, m_cdwr, m_rv0, m_rv1, m_rdata);
   endfunction

   function automatic void model_reset();
      owner = -1; cnt = 0; last = 1; pend = 0;
      m_cwr = 0; m_crd = 0; m_rv0 = 0; m_rv1 = 0; m_csel = 0;
      m_cawr = 0; m_card = 0; m_cdwr = 0; m_rdata = 0;
   endfunction

   function automatic void model_step();
      logic rq[2], w[2];
      logic [2:0] s[2];
      logic [11:0] a[2];
      logic [19:0] d[2];
      int ak, nx, o;
      rq[0] = req0; rq[1] = req1; w[0] = we0; w[1] = we1;
      s[0] = sel0; s[1] = sel1; a[0] = addr0; a[1] = addr1;
      d[0] = wdata0; d[1] = wdata1;
      m_rv0 = m_crd && pend == 0;
      m_rv1 = m_crd && pend == 1;
      if (m_crd) m_rdata = cdata_rd;
      ak = (owner >= 0 && rq[owner]) ? owner : -1;
      m_cwr = 0; m_crd = 0; m_csel = 0;
      if (ak >= 0) begin
         m_csel = s[ak];
         if (w[ak]) begin
            m_cwr = 1; m_cawr = a[ak]; m_cdwr = d[ak];
         end else begin
            m_crd = 1; m_card = a[ak]; pend = ak;
         end
      end
      if (owner < 0) begin
         nx = -1;
         if (rq[0] && rq[1]) nx = RR ? 1 - last : 0;
         else if (rq[0]) nx = 0;
         else if (rq[1]) nx = 1;
         if (nx >= 0) begin owner = nx; cnt = 0; last = nx; end
      end else begin
         o = owner;
         if (!rq[o] || cnt + 1 == BM) begin
            cnt = 0;
            if (rq[1-o]) owner = 1 - o;
            else if (rq[o]) owner = o;
            else owner = -1;
            if (owner >= 0) last = owner;
         end else begin
            cnt = cnt + 1;
         end
      end
   endfunction

   task automatic check(input string nm, input logic [72:0] act,
                        input logic [72:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; sel0 = 0; sel1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; cdata_rd = 0;
   endtask

   task automatic tick(input string nm);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check(nm, dut_act(), model_exp());
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      check("reset_state", dut_act(), 73'd0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic        r0, w0;
      logic [11:0] a0;
      logic [19:0] d0;
      logic        r1, w1;
      logic [11:0] a1;
      logic [19:0] md;
      logic [72:0] e;
   } vec_t;

   vec_t tv[9];

   function automatic vec_t mkv(
      input logic r0, input logic w0, input logic [11:0] a0,
      input logic [19:0] d0, input logic r1, input logic w1,
      input logic [11:0] a1, input logic [19:0] md, input logic [72:0] e);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.md = md; v.e = e;
      return v;
   endfunction

   initial begin
      logic e0;
      clear_inputs();
      model_reset();

      // directed vectors: three writes from requester 0, then a read from requester 1
      tv[0] = mkv(1'b1, 1'b1, 12'h000, 20'h00011, 1'b0, 1'b0, 12'h000, 20'h0,
         pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 12'h0, 12'h0, 20'h0, 1'b0, 1'b0, 20'h0));
      tv[1] = mkv(1'b1, 1'b1, 12'h000, 20'h00011, 1'b0, 1'b0, 12'h000, 20'h0,
         pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 12'h0, 12'h0, 20'h11, 1'b0, 1'b0, 20'h0));
      tv[2] = mkv(1'b1, 1'b1, 12'h001, 20'h00012, 1'b0, 1'b0, 12'h000, 20'h0,
         pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 12'h1, 12'h0, 20'h12, 1'b0, 1'b0, 20'h0));
      tv[3] = mkv(1'b1, 1'b1, 12'h002, 20'h00013, 1'b0, 1'b0, 12'h000, 20'h0,
         pk(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 12'h2, 12'h0, 20'h13, 1'b0, 1'b0, 20'h0));
      tv[4] = mkv(1'b0, 1'b0, 12'h000, 20'h0, 1'b0, 1'b0, 12'h000, 20'h0,
         pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h2, 12'h0, 20'h13, 1'b0, 1'b0, 20'h0));
      tv[5] = mkv(1'b0, 1'b0, 12'h000, 20'h0, 1'b1, 1'b0, 12'h040, 20'h0,
         pk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 12'h2, 12'h0, 20'h13, 1'b0, 1'b0, 20'h0));
      tv[6] = mkv(1'b0, 1'b0, 12'h000, 20'h0, 1'b1, 1'b0, 12'h040, 20'h0,
         pk(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 12'h2, 12'h40, 20'h13, 1'b0, 1'b0, 20'h0));
      tv[7] = mkv(1'b0, 1'b0, 12'h000, 20'h0, 1'b0, 1'b0, 12'h000, 20'h0ABCD,
         pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h2, 12'h40, 20'h13, 1'b0, 1'b1, 20'h0ABCD));
      tv[8] = mkv(1'b0, 1'b0, 12'h000, 20'h0, 1'b0, 1'b0, 12'h000, 20'h0,
         pk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'h2, 12'h40, 20'h13, 1'b0, 1'b0, 20'h0ABCD));

      do_reset();
      sel0 = 3'd5; sel1 = 3'd3;
      for (int i = 0; i < 9; i++) begin
         req0 = tv[i].r0; we0 = tv[i].w0; addr0 = tv[i].a0; wdata0 = tv[i].d0;
         req1 = tv[i].r1; we1 = tv[i].w1; addr1 = tv[i].a1; cdata_rd = tv[i].md;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d", i), dut_act(), tv[i].e);
      end

      // contests from IDLE
      do_reset();
      req0 = 1; req1 = 1; we0 = 1; we1 = 1;
      tick("c1");
      check("contest1", 73'({gnt0, gnt1}), 73'(2'b10));
      req0 = 0; req1 = 0;
      tick("c_idle");
      req0 = 1; req1 = 1;
      tick("c2");
      check("contest2", 73'({gnt0, gnt1}), RR ? 73'(2'b01) : 73'(2'b10));

      // continuous demand alternates every BM beats with no gap
      do_reset();
      req0 = 1; req1 = 1; we0 = 1; we1 = 1;
      for (int k = 1; k <= 16; k++) begin
         addr0 = 12'($urandom); addr1 = 12'($urandom);
         wdata0 = 20'($urandom); wdata1 = 20'($urandom);
         tick("alt");
         e0 = (((k - 1) / BM) % 2) == 0;
         check($sformatf("alt_gnt%0d", k), 73'({gnt0, gnt1}), 73'({e0, ~e0}));
         if (k >= 2) check($sformatf("alt_cwr%0d", k), 73'(cwr), 73'(1'b1));
      end

      // read return follows its requester after handover
      do_reset();
      req0 = 1; we0 = 0; sel0 = 3'd1; addr0 = 12'h077;
      req1 = 1; we1 = 1; sel1 = 3'd6; addr1 = 12'h0AA; wdata1 = 20'h12345;
      tick("h1");
      tick("h2");
      req0 = 0; cdata_rd = 20'h5A5A5;
      tick("h3");
      check("handover_ret", 73'({gnt1, rvalid0, rvalid1, rdata}),
            73'({1'b1, 1'b1, 1'b0, 20'h5A5A5}));
      cdata_rd = 20'h0;
      tick("h4");
      check("handover_once", 73'({rvalid0, rvalid1}), 73'(2'b00));

      // asynchronous reset with a read in flight
      do_reset();
      req0 = 1; we0 = 0; sel0 = 3'd2; addr0 = 12'h123;
      tick("r1");
      tick("r2");
      check("inflight_crd", 73'(crd), 73'(1'b1));
      #1 reset = 1'b1;
      #1 check("async_reset", dut_act(), 73'd0);
      req0 = 0; cdata_rd = 20'hFFFFF;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) tick("post_reset");

      // random traffic
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         req0 = $urandom_range(0, 3) != 0;
         req1 = $urandom_range(0, 3) != 0;
         we0 = 1'($urandom); we1 = 1'($urandom);
         sel0 = 3'($urandom); sel1 = 3'($urandom);
         addr0 = 12'($urandom); addr1 = 12'($urandom);
         wdata0 = 20'($urandom); wdata1 = 20'($urandom);
         cdata_rd = 20'($urandom);
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
